ram_responder: RTL and testbench

- Memory-side responder for the pipeline's instruction/data RAM handshake (re/addr in; data/busy/done out).
- Accepts one read or write request at a time, holds busy for a programmable latency, then pulses done with read data valid.
- Sits between the IF/MEM request ports and a word-organised internal storage array.
- Also serves as the simulation RAM model.

---
 rtl/ram_responder.sv | 159 +++++++++++++++
 tb/tb_ram_responder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_responder.sv
// Word-organised RAM responder: one request at a time, busy for LATENCY-1 cycles, then a done pulse.
// Optional macro RAM_DROP_CHECK_EN adds drop_o, flagging requests that arrive while busy.
module ram_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 12,
  parameter int LATENCY    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  re_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [3:0]            be_i,
`ifdef RAM_DROP_CHECK_EN
  output logic                  drop_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [3:0]              cnt_r;
  logic [DEPTH_LOG2-1:0]   idx_r, cur_idx_s;
  logic                    wr_r, cur_wr_s;
  logic [DATA_WIDTH-1:0]   wdata_r, cur_wdata_s;
  logic [3:0]              be_r, cur_be_s;
  logic [DATA_WIDTH-1:0]   data_r;
  logic                    busy_r, done_r;
  logic                    accept_s, commit_s;
  logic [DATA_WIDTH-1:0]   mem_r [0:DEPTH-1];
  logic                    unused_addr_s;

  assign unused_addr_s = ^{addr_i[1:0], addr_i[ADDR_WIDTH-1:DEPTH_LOG2+2]};
  assign accept_s      = (re_i | we_i) & ((state_r == ST_IDLE) | (state_r == ST_DONE));
  // Array access happens on the edge that enters DONE; gated so nothing commits while held in reset.
  assign commit_s      = rst & (state_nxt_s == ST_DONE);

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (accept_s) begin
          state_nxt_s = (LATENCY > 1) ? ST_BUSY : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == 4'd1) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is the accept edge, so use live inputs then
  always_comb begin
    cur_idx_s   = idx_r;
    cur_wr_s    = wr_r;
    cur_wdata_s = wdata_r;
    cur_be_s    = be_r;
    if (accept_s) begin
      cur_idx_s   = addr_i[DEPTH_LOG2+1:2];
      cur_wr_s    = we_i;
      cur_wdata_s = wdata_i;
      cur_be_s    = be_i;
    end else begin
      cur_idx_s   = idx_r;
    end
  end

  // Control state, latched request and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      idx_r   <= '0;
      wr_r    <= 1'b0;
      wdata_r <= '0;
      be_r    <= 4'd0;
      data_r  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_BUSY);
      done_r  <= (state_nxt_s == ST_DONE);
      if (accept_s) begin
        cnt_r   <= CNT_LOAD;
        idx_r   <= cur_idx_s;
        wr_r    <= cur_wr_s;
        wdata_r <= cur_wdata_s;
        be_r    <= cur_be_s;
      end else if (state_r == ST_BUSY) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // A write with re_i also high drops the read, so data_o holds
      if (commit_s && !cur_wr_s) begin
        data_r <= mem_r[cur_idx_s];
      end
    end
  end

  // Storage array, byte-lane writes; never cleared by reset
  always_ff @(posedge clk) begin
    if (commit_s && cur_wr_s) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_be_s[b]) begin
          mem_r[cur_idx_s][8*b +: 8] <= cur_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign data_o = data_r;
  assign busy_o = busy_r;
  assign done_o = done_r;

`ifdef RAM_DROP_CHECK_EN
  logic drop_r;

  // Flag any request sampled while a previous one is in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_r <= 1'b0;
    end else begin
      drop_r <= (re_i | we_i) & (state_r == ST_BUSY);
    end
  end

`ifndef SYNTHESIS
  // Simulation-only report of the ignored address
  always_ff @(posedge clk) begin
    if (rst && (re_i | we_i) && (state_r == ST_BUSY)) begin
      $display("ram_responder: request to addr %h ignored while busy", addr_i);
    end
  end
`endif

  assign drop_o = drop_r;
`endif

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: directed scenarios plus randomized traffic against a word-array model.
// Instantiates a LATENCY=3 unit and a LATENCY=1 unit.
module tb_ram_responder;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        re_i = 1'b0, we_i = 1'b0;
  logic [31:0] addr_i = 32'd0, wdata_i = 32'd0;
  logic [3:0]  be_i = 4'd0;
  logic [31:0] data_o;
  logic        busy_o, done_o;
  logic        re1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = 32'd0, wd1 = 32'd0;
  logic [3:0]  be1 = 4'd0;
  logic [31:0] data1;
  logic        busy1, done1;
`ifdef RAM_DROP_CHECK_EN
  logic        drop_o, drop1;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] mdl [int];
  logic [31:0] exp_rd = 32'd0;

  always #5 clk = ~clk;

  ram_responder #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .re_i(re_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .be_i(be_i),
`ifdef RAM_DROP_CHECK_EN
    .drop_o(drop_o),
`endif
    .data_o(data_o), .busy_o(busy_o), .done_o(done_o));

  ram_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .re_i(re1), .we_i(we1), .addr_i(addr1),
    .wdata_i(wd1), .be_i(be1),
`ifdef RAM_DROP_CHECK_EN
    .drop_o(drop1),
`endif
    .data_o(data1), .busy_o(busy1), .done_o(done1));

  // Reference: word array indexed modulo 4096, byte lanes merged with plain arithmetic
  function automatic void model_apply(input logic re, input logic we, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic [3:0] be);
    int idx;
    logic [31:0] w;
    idx = int'((addr / 4) % 4096);
    if (we) begin
      w = mdl.exists(idx) ? mdl[idx] : 32'd0;
      for (int b = 0; b < 4; b++)
        if (be[b]) w = (w & ~(32'hFF << (8*b))) | (wd & (32'hFF << (8*b)));
      mdl[idx] = w;
    end else if (re) begin
      exp_rd = mdl.exists(idx) ? mdl[idx] : 32'd0;
    end
  endfunction

  task automatic drive_req(input logic re, input logic we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    re_i = re; we_i = we; addr_i = addr; wdata_i = wd; be_i = be;
    @(posedge clk);
    #1;
    re_i = 1'b0; we_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0; be_i = 4'd0;
  endtask

  task automatic wait_done(input logic [31:0] hold, input string tag);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      chk_cnt++;
      if (busy_o !== (k < LAT)) $display("FAIL %s busy k=%0d got %b want %b", tag, k, busy_o, (k < LAT));
      else pass_cnt++;
      chk_cnt++;
      if (done_o !== (k == LAT)) $display("FAIL %s done k=%0d got %b want %b", tag, k, done_o, (k == LAT));
      else pass_cnt++;
      if (k < LAT) begin
        chk_cnt++;
        if (data_o !== hold) $display("FAIL %s hold k=%0d got %h want %h", tag, k, data_o, hold);
        else pass_cnt++;
      end
    end
  endtask

  task automatic run_op(input bit sync, input logic re, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be, input string tag);
    logic [31:0] hold;
    hold = exp_rd;
    if (sync) @(negedge clk);
    drive_req(re, we, addr, wd, be);
    model_apply(re, we, addr, wd, be);
    wait_done(hold, tag);
    chk_cnt++;
    if (data_o !== exp_rd) $display("FAIL %s data got %h want %h", tag, data_o, exp_rd);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if ({busy_o, done_o, data_o} !== 34'd0) $display("FAIL reset dut got %b %b %h want 0", busy_o, done_o, data_o);
    else pass_cnt++;
    chk_cnt++;
    if ({busy1, done1, data1} !== 34'd0) $display("FAIL reset dut1 got %b %b %h want 0", busy1, done1, data1);
    else pass_cnt++;
`ifdef RAM_DROP_CHECK_EN
    chk_cnt++;
    if (drop_o !== 1'b0) $display("FAIL reset drop got %b want 0", drop_o);
    else pass_cnt++;
`endif
    rst = 1'b1;
  endtask

  task automatic test_basic();
    run_op(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "basic_wr");
    run_op(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "basic_rd");
    chk_cnt++;
    if (data_o !== 32'hDEADBEEF) $display("FAIL basic_const got %h want deadbeef", data_o);
    else pass_cnt++;
  endtask

  task automatic test_partial();
    run_op(1'b1, 1'b0, 1'b1, 32'h30, 32'h11223344, 4'hF, "part_init");
    run_op(1'b1, 1'b0, 1'b1, 32'h30, 32'h0000AA00, 4'b0010, "part_wr");
    run_op(1'b1, 1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, "part_noop");
    run_op(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 4'h0, "part_rd");
    chk_cnt++;
    if (data_o !== 32'h1122AA44) $display("FAIL part_const got %h want 1122aa44", data_o);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 1'b0, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, "b2b_w0");
    run_op(1'b1, 1'b0, 1'b1, 32'h4, 32'h5B5B5B5B, 4'hF, "b2b_w4");
    run_op(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, "b2b_r0");
    run_op(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "b2b_r4");
    // write issued in a read's done cycle, then read-after-write in the write's done cycle
    run_op(1'b0, 1'b0, 1'b1, 32'h4, 32'h0C0C0C0C, 4'hF, "b2b_w4b");
    run_op(1'b0, 1'b1, 1'b0, 32'h4, 32'h0, 4'h0, "b2b_raw");
  endtask

  task automatic test_both_ops();
    run_op(1'b1, 1'b1, 1'b1, 32'h8, 32'h77665544, 4'hF, "both");
    run_op(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'h0, "both_rd");
  endtask

  task automatic test_busy_ignore();
    int dones;
    dones = 0;
    @(negedge clk);
    drive_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    model_apply(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
    @(negedge clk);
    if (done_o) dones++;
    drive_req(1'b1, 1'b1, 32'h10, 32'h0BADF00D, 4'hF);
    for (int k = 2; k <= 6; k++) begin
      @(negedge clk);
      if (done_o) dones++;
`ifdef RAM_DROP_CHECK_EN
      if (k <= 3) begin
        chk_cnt++;
        if (drop_o !== (k == 2)) $display("FAIL drop k=%0d got %b want %b", k, drop_o, (k == 2));
        else pass_cnt++;
      end
`endif
      if (k == LAT) begin
        chk_cnt++;
        if (done_o !== 1'b1 || data_o !== exp_rd) $display("FAIL ignore_done got %b %h want 1 %h", done_o, data_o, exp_rd);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (dones != 1) $display("FAIL ignore_pulses got %0d want 1", dones);
    else pass_cnt++;
    run_op(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, "ignore_rd");
  endtask

  task automatic test_reset_midop();
    int dones;
    dones = 0;
    run_op(1'b1, 1'b0, 1'b1, 32'h20, 32'h55667788, 4'hF, "rst_old");
    run_op(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "rst_oldrd");
    @(negedge clk);
    drive_req(1'b0, 1'b1, 32'h20, 32'h99999999, 4'hF);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk_cnt++;
    if ({busy_o, done_o, data_o} !== 34'd0) $display("FAIL rst_mid got %b %b %h want 0", busy_o, done_o, data_o);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b1;
    exp_rd = 32'd0;
    repeat (4) begin
      @(negedge clk);
      if (done_o || busy_o) dones++;
    end
    chk_cnt++;
    if (dones != 0) $display("FAIL rst_nodone got %0d want 0", dones);
    else pass_cnt++;
    run_op(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, "rst_readback");
  endtask

  task automatic test_latency_one();
    logic [31:0] addrs [2];
    addrs[0] = 32'h0;
    addrs[1] = 32'h4003;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      re1 = (i == 1); we1 = (i == 0); addr1 = addrs[i]; wd1 = 32'hCAFEF00D; be1 = 4'hF;
      @(posedge clk);
      #1;
      re1 = 1'b0; we1 = 1'b0; addr1 = 32'd0; wd1 = 32'd0; be1 = 4'd0;
      @(negedge clk);
      chk_cnt++;
      if (busy1 !== 1'b0 || done1 !== 1'b1) $display("FAIL lat1_%0d got busy %b done %b want 0 1", i, busy1, done1);
      else pass_cnt++;
      chk_cnt++;
      if (data1 !== ((i == 1) ? 32'hCAFEF00D : 32'd0)) $display("FAIL lat1_data%0d got %h", i, data1);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL lat1_after%0d got busy %b done %b want 0 0", i, busy1, done1);
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int kind;
    for (int i = 0; i < 16; i++)
      run_op(1'b1, 1'b0, 1'b1, 32'h100 + 32'(4*i), $urandom, 4'hF, "rnd_init");
    for (int n = 0; n < 150; n++) begin
      addr = ($urandom & 32'hFFFF_C000) | 32'h100 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      kind = $urandom_range(0, 3);
      run_op(($urandom_range(0, 1) == 1), (kind < 2), (kind >= 2), addr, $urandom,
             4'($urandom_range(0, 15)), "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_both_ops();
    test_busy_ignore();
    test_reset_midop();
    test_latency_one();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
